// File: rtl/tm1638_pkg.sv
// Shared types and field positions for the TM1638 command serializer.
package tm1638_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT    = 3'd2,
    BYTE_END = 3'd3,
    GAP      = 3'd4
  } state_t;

  // Command word layout: [16]=LAST, [15:8]=reserved, [7:0]=byte
  localparam int LAST_BIT = 16;
  localparam int BYTE_MSB = 7;
  localparam int BYTE_LSB = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tm1638_serializer_if.sv
// FIFO-side and TM1638-bus-side signals of the serializer, bundled with modports.
interface tm1638_serializer_if #(
  parameter int DATA_WIDTH = 17
);
  // Handshake: i_Empty=0 means i_Data holds a valid head word (first-word
  // fall-through); o_Read is a one-cycle strobe that consumes that word on the
  // same clock edge it is sampled high. The bus side is a write-only 3-wire link.
  logic                  i_Empty;
  logic                  o_Read;
  logic [DATA_WIDTH-1:0] i_Data;
  logic                  o_Stb;
  logic                  o_Sclk;
  logic                  o_Dio;
  logic                  o_Busy;

  modport master (
    input  i_Empty,
    input  i_Data,
    output o_Read,
    output o_Stb,
    output o_Sclk,
    output o_Dio,
    output o_Busy
  );

  modport slave (
    output i_Empty,
    output i_Data,
    input  o_Read,
    input  o_Stb,
    input  o_Sclk,
    input  o_Dio,
    input  o_Busy
  );
endinterface

// File: rtl/tm1638_tick.sv
// Loadable down-counter: loading N yields a one-cycle done pulse N-1 cycles later,
// so a phase started on the load edge lasts exactly N cycles.
module tm1638_tick #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/tm1638_serializer.sv
// Pops 17-bit command words from a FWFT FIFO and shifts them LSB-first onto the TM1638
// STB/CLK/DIO bus. Define TM1638_DIAG_EN to expose the FSM state on o_Diag_State.
module tm1638_serializer
  import tm1638_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int CLK_HALF   = 8,
  parameter int STB_GAP    = 16,
  parameter int BYTE_GAP   = 4
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
`ifdef TM1638_DIAG_EN
  output logic [2:0] o_Diag_State,
`endif
  tm1638_serializer_if.master bus
);

  localparam int CNT_W = $clog2(max3(CLK_HALF, STB_GAP, BYTE_GAP) + 1);

  state_t          state, state_next;
  logic [7:0]      shreg, shreg_next;
  logic            last, last_next;
  logic [2:0]      bit_cnt, bit_cnt_next;
  logic            stb_q, stb_next;
  logic            sclk_q, sclk_next;
  logic            dio_q, dio_next;
  logic            read_q, read_next;
  logic            busy_q;
  logic            tick_load, tick_done;
  logic [CNT_W-1:0] tick_val;

  logic [DATA_WIDTH-1:0] head;
  logic                  unused_reserved;

  assign head            = bus.i_Data;
  assign unused_reserved = ^head[15:8];

  tm1638_tick #(.W(CNT_W)) u_tick (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .load     (tick_load),
    .load_val (tick_val),
    .done     (tick_done)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      last    <= 1'b0;
      bit_cnt <= '0;
      stb_q   <= 1'b1;
      sclk_q  <= 1'b1;
      dio_q   <= 1'b1;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      last    <= last_next;
      bit_cnt <= bit_cnt_next;
      stb_q   <= stb_next;
      sclk_q  <= sclk_next;
      dio_q   <= dio_next;
      read_q  <= read_next;
      busy_q  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    last_next    = last;
    bit_cnt_next = bit_cnt;
    stb_next     = stb_q;
    sclk_next    = sclk_q;
    dio_next     = dio_q;
    read_next    = 1'b0;
    tick_load    = 1'b0;
    tick_val     = '0;
    unique case (state)
      IDLE: begin
        // STB is left untouched here so a LAST=0 word keeps the frame open
        if (!bus.i_Empty) begin
          shreg_next = head[BYTE_MSB:BYTE_LSB];
          last_next  = head[LAST_BIT];
          read_next  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        stb_next     = 1'b0;
        sclk_next    = 1'b0;
        dio_next     = shreg[0];
        bit_cnt_next = '0;
        tick_load    = 1'b1;
        tick_val     = CNT_W'(CLK_HALF);
        state_next   = SHIFT;
      end
      SHIFT: begin
        if (tick_done) begin
          if (!sclk_q) begin
            sclk_next = 1'b1;
            tick_load = 1'b1;
            tick_val  = CNT_W'(CLK_HALF);
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            tick_load    = 1'b1;
            if (bit_cnt == 3'd7) begin
              tick_val   = CNT_W'(BYTE_GAP);
              state_next = BYTE_END;
            end else begin
              // Next bit goes out together with the falling SCLK edge
              sclk_next = 1'b0;
              dio_next  = shreg[bit_cnt_next];
              tick_val  = CNT_W'(CLK_HALF);
            end
          end
        end
      end
      BYTE_END: begin
        if (last) begin
          stb_next   = 1'b1;
          dio_next   = 1'b1;
          tick_load  = 1'b1;
          tick_val   = CNT_W'(STB_GAP);
          state_next = GAP;
        end else if (tick_done) begin
          state_next = IDLE;
        end
      end
      GAP: begin
        if (tick_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.o_Read = read_q;
  assign bus.o_Stb  = stb_q;
  assign bus.o_Sclk = sclk_q;
  assign bus.o_Dio  = dio_q;
  assign bus.o_Busy = busy_q;

`ifdef TM1638_DIAG_EN
  assign o_Diag_State = state;
`endif

endmodule

// File: tb/tb_tm1638_serializer.sv
// Bench for tm1638_serializer behind a 4-deep FWFT FIFO model; decodes the STB/CLK/DIO
// stream and scores bytes (with their frame number) against the push order.
module tb_tm1638_serializer;

  localparam int CLK_HALF = 2;
  localparam int STB_GAP  = 4;
  localparam int BYTE_GAP = 2;
  localparam int DEPTH    = 4;
  localparam int NV       = 7;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tm1638_serializer_if #(.DATA_WIDTH(17)) bus ();

`ifdef TM1638_DIAG_EN
  logic [2:0] diag_state;
`endif

  tm1638_serializer #(
    .DATA_WIDTH (17),
    .CLK_HALF   (CLK_HALF),
    .STB_GAP    (STB_GAP),
    .BYTE_GAP   (BYTE_GAP)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
`ifdef TM1638_DIAG_EN
    .o_Diag_State (diag_state),
`endif
    .bus          (bus)
  );

  // FIFO model (first-word fall-through)
  logic [16:0] fifo_mem [DEPTH];
  int          fifo_count = 0;
  int          rd_ptr     = 0;
  int          wr_ptr     = 0;
  int          pop_total  = 0;
  int          push_total = 0;
  logic        push_en    = 1'b0;
  logic [16:0] push_data  = '0;

  assign bus.i_Empty = (fifo_count == 0);
  assign bus.i_Data  = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (push_en && fifo_count < DEPTH) begin
      fifo_mem[wr_ptr] <= push_data;
      wr_ptr           <= (wr_ptr + 1) % DEPTH;
    end
    if (bus.o_Read && fifo_count > 0) begin
      rd_ptr    <= (rd_ptr + 1) % DEPTH;
      pop_total <= pop_total + 1;
    end
    fifo_count <= fifo_count + ((push_en && fifo_count < DEPTH) ? 1 : 0)
                             - ((bus.o_Read && fifo_count > 0) ? 1 : 0);
  end

  // scoreboard
  int          errors    = 0;
  int          checks    = 0;
  int          exp_frame = 0;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic push_word(input logic [16:0] w, input logic [7:0] exp_byte, input bit exp_out);
    int guard;
    guard = 0;
    while (fifo_count >= DEPTH && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check("push_wait_timeout", 1, 0);
    if (exp_out) exp_q.push_back({exp_frame[7:0], exp_byte});
    if (w[16]) exp_frame++;
    push_en   = 1'b1;
    push_data = w;
    push_total++;
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && fifo_count == 0 && !bus.o_Busy) && guard < 4000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 4000) check({name, "_idle_timeout"}, 1, 0);
  endtask

  // bus monitor, sampled on the falling system clock edge
  int         mon_bits       = 0;
  int         mon_frame      = 0;
  int         bytes_in_frame = 0;
  int         sclk_high_run  = 0;
  int         stb_high_run   = 0;
  logic [7:0] mon_shift      = '0;
  logic       prev_stb       = 1'b1;
  logic       prev_sclk      = 1'b1;
  logic       prev_read      = 1'b0;

  initial begin
    logic [15:0] exp_entry;
    forever begin
      @(negedge clk);
      if (bus.o_Read) begin
        check("read_single_cycle", {31'd0, prev_read}, 0);
        check("read_nonempty", {31'd0, fifo_count > 0}, 1);
      end
      if (!bus.o_Sclk) check("sclk_low_inside_frame", {31'd0, bus.o_Stb}, 0);
      if (prev_stb && !bus.o_Stb)
        check("stb_high_gap", {31'd0, stb_high_run >= STB_GAP}, 1);
      if (!prev_stb && bus.o_Stb) begin
        mon_frame++;
        mon_bits       = 0;
        bytes_in_frame = 0;
      end
      if (!bus.o_Stb && prev_sclk && !bus.o_Sclk && mon_bits == 0 && bytes_in_frame > 0)
        check("byte_gap_sclk_high", {31'd0, sclk_high_run >= CLK_HALF + BYTE_GAP}, 1);
      if (!bus.o_Stb && !prev_sclk && bus.o_Sclk) begin
        mon_shift = {bus.o_Dio, mon_shift[7:1]};
        mon_bits++;
        if (mon_bits == 8) begin
          mon_bits = 0;
          bytes_in_frame++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {16'd0, mon_frame[7:0], mon_shift}, 32'hFFFF_FFFF);
          end else begin
            exp_entry = exp_q.pop_front();
            check("byte_frame", {16'd0, mon_frame[7:0], mon_shift}, {16'd0, exp_entry});
          end
        end
      end
      stb_high_run  = bus.o_Stb  ? stb_high_run + 1  : 0;
      sclk_high_run = bus.o_Sclk ? sclk_high_run + 1 : 0;
      prev_stb      = bus.o_Stb;
      prev_sclk     = bus.o_Sclk;
      prev_read     = bus.o_Read;
    end
  end

  typedef struct {
    logic [16:0] word;
    logic [7:0]  exp_byte;
    bit          wait_after;
    logic        exp_stb;
    int          hold;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int guard;

    vecs[0] = '{17'h1_0040, 8'h40, 1'b1, 1'b1, 0};
    vecs[1] = '{17'h0_00C0, 8'hC0, 1'b0, 1'b0, 0};
    vecs[2] = '{17'h0_00FF, 8'hFF, 1'b0, 1'b0, 0};
    vecs[3] = '{17'h1_0001, 8'h01, 1'b1, 1'b1, 0};
    vecs[4] = '{17'h0_0044, 8'h44, 1'b1, 1'b0, 20};
    vecs[5] = '{17'h1_0012, 8'h12, 1'b1, 1'b1, 0};
    vecs[6] = '{17'h1_AB33, 8'h33, 1'b1, 1'b1, 0};

    // reset held, FIFO empty
    repeat (3) begin
      @(negedge clk);
      check("reset_bus_levels", {27'd0, bus.o_Stb, bus.o_Sclk, bus.o_Dio, bus.o_Read, bus.o_Busy},
            32'b11100);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_empty_levels", {27'd0, bus.o_Stb, bus.o_Sclk, bus.o_Dio, bus.o_Read, bus.o_Busy},
            32'b11100);
    end
    check("idle_empty_no_pop", pop_total, 0);

    // single byte, multi-byte frame, starvation, reserved bits
    for (int i = 0; i < NV; i++) begin
      push_word(vecs[i].word, vecs[i].exp_byte, 1'b1);
      if (vecs[i].wait_after) begin
        wait_idle($sformatf("vec%0d", i));
        repeat (vecs[i].hold) @(negedge clk);
        check($sformatf("vec%0d_stb_idle", i), {31'd0, bus.o_Stb}, {31'd0, vecs[i].exp_stb});
        check($sformatf("vec%0d_busy_idle", i), {31'd0, bus.o_Busy}, 0);
      end
    end

    // reset in the middle of a byte: the popped word is lost, nothing re-read
    push_word(17'h1_00A5, 8'hA5, 1'b0);
    guard = 0;
    while (!(mon_bits == 4 && !bus.o_Stb) && guard < 500) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 500) check("mid_byte_wait_timeout", 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_bus", {29'd0, bus.o_Stb, bus.o_Sclk, bus.o_Dio}, 32'b111);
    check("rst_async_read_busy", {30'd0, bus.o_Read, bus.o_Busy}, 0);
    repeat (3) @(negedge clk);
    check("rst_fifo_unchanged", fifo_count, 0);
    check("rst_no_repop", pop_total, push_total);
    rst_n = 1'b1;
    @(negedge clk);
    push_word(17'h1_005A, 8'h5A, 1'b1);
    wait_idle("after_reset");
    check("after_reset_stb", {31'd0, bus.o_Stb}, 1);

    // random push timing, incrementing bytes, LAST on every third word
    for (int i = 0; i < 30; i++) begin
      logic [16:0] w;
      w = {1'(i % 3 == 2), 8'h00, 8'(8'h60 + i)};
      push_word(w, w[7:0], 1'b1);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle("random");
    check("random_drained", exp_q.size(), 0);
    check("random_pop_count", pop_total, push_total);
    check("random_final_stb", {31'd0, bus.o_Stb}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
